// File: rtl/ibex_imem_req_ctrl_pkg.sv
// rtl/ibex_imem_req_ctrl_pkg.sv - shared constants for the instruction-memory request controller
//
// Purpose: default outstanding-request depth and address alignment masks.
package ibex_imem_req_ctrl_pkg;

    // Default number of granted-but-unanswered requests; must match the fetch FIFO.
    localparam int unsigned NUM_REQS_DEFAULT = 2;

    // Bus fetches are word aligned.
    localparam logic [31:0] FETCH_WORD_MASK = 32'hFFFF_FFFC;

    // FIFO restart address is halfword aligned (compressed instructions).
    localparam logic [31:0] FETCH_HALF_MASK = 32'hFFFF_FFFE;

endpackage

// File: rtl/ibex_imem_req_ctrl.sv
// rtl/ibex_imem_req_ctrl.sv - instruction-memory fetch request issue and response tracking
//
// Purpose: issues word-aligned instruction bus requests, tracks up to NUM_REQS
// outstanding responses, discards responses to fetches made before a branch and
// forwards surviving responses to the fetch FIFO.
//
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_i, branch_i, addr_i            IF-stage fetch enable and redirect
//   fifo_ready_i                       fetch FIFO has room for one more response
//   fifo_clear_o, fifo_addr_o          FIFO flush and restart address
//   fifo_valid_o/rdata_o/err_o         surviving response to the FIFO
//   busy_o                             request pending or responses outstanding
//   instr_req_o/gnt_i/addr_o           instruction bus request channel
//   instr_rvalid_i/rdata_i/err_i       instruction bus response channel
module ibex_imem_req_ctrl
    import ibex_imem_req_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQS = NUM_REQS_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        fifo_ready_i,
    output logic        fifo_clear_o,
    output logic [31:0] fifo_addr_o,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o,
    output logic        busy_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);

    logic [31:0]         r_fetch_addr;
    logic                r_req_pending;
    logic [NUM_REQS-1:0] r_outstanding;   // thermometer code, bit0 = oldest
    logic [NUM_REQS-1:0] r_discard;       // aligned with r_outstanding

    logic                w_new_req;
    logic                w_req;
    logic                w_gnt;
    logic                w_rvalid;
    logic [31:0]         w_branch_addr;
    logic [31:0]         w_addr;
    logic [NUM_REQS-1:0] w_out_shift;
    logic [NUM_REQS-1:0] w_disc_shift;
    logic [NUM_REQS-1:0] w_out_next;
    logic [NUM_REQS-1:0] w_disc_next;

    assign w_branch_addr = addr_i & FETCH_WORD_MASK;

    // A new request needs a free tracker slot; an ungranted one is held regardless.
    assign w_new_req = req_i & fifo_ready_i & ~r_outstanding[NUM_REQS-1];
    assign w_req     = w_new_req | r_req_pending;
    assign w_addr    = branch_i ? w_branch_addr : r_fetch_addr;
    assign w_gnt     = w_req & instr_gnt_i;
    assign w_rvalid  = instr_rvalid_i & r_outstanding[0];

    always_comb begin
        w_out_shift  = r_outstanding;
        w_disc_shift = r_discard;
        if (w_rvalid) begin
            w_out_shift  = {1'b0, r_outstanding[NUM_REQS-1:1]};
            w_disc_shift = {1'b0, r_discard[NUM_REQS-1:1]};
        end

        // Appending sets the lowest free slot; its discard bit is already clear
        // because discard bits only ever sit on occupied slots.
        w_out_next = w_out_shift;
        if (w_gnt) begin
            w_out_next = {w_out_shift[NUM_REQS-2:0], 1'b1};
        end

        // A branch condemns everything still in flight after this cycle's retire,
        // but not a grant taken in the same cycle (that one is for the new target).
        w_disc_next = branch_i ? w_out_shift : w_disc_shift;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_addr  <= 32'h0;
            r_req_pending <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_req_pending <= w_req & ~instr_gnt_i;
            r_outstanding <= w_out_next;
            r_discard     <= w_disc_next;
            if (w_gnt) begin
                r_fetch_addr <= w_addr + 32'd4;
            end else if (branch_i) begin
                r_fetch_addr <= w_branch_addr;
            end
        end
    end

    assign instr_req_o  = w_req;
    assign instr_addr_o = w_addr;

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i & FETCH_HALF_MASK;
    assign fifo_valid_o = w_rvalid & ~r_discard[0];
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

    assign busy_o = w_req | r_outstanding[0];

    // The bus must never answer a request that was not granted.
    a_rvalid_expected: assert property (
        @(posedge clk_i) disable iff (!rst_ni) instr_rvalid_i |-> r_outstanding[0]
    );

endmodule

// File: tb/tb_ibex_imem_req_ctrl.sv
// tb/tb_ibex_imem_req_ctrl.sv - self-checking bench for ibex_imem_req_ctrl
module tb_ibex_imem_req_ctrl;

    localparam int NUM_REQS = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, branch, ready, gnt, rvalid, err;
    logic [31:0] addr, rdata;

    logic        fifo_clear_o, fifo_valid_o, fifo_err_o, busy_o, instr_req_o;
    logic [31:0] fifo_addr_o, fifo_rdata_o, instr_addr_o;

    int checks = 0;
    int failures = 0;

    // Reference model: pending-request flag, next fetch address and a queue of
    // in-flight fetches, each tagged with whether its response must be dropped.
    logic [31:0] m_fetch;
    bit          m_pending;
    bit          mq[$];
    logic        exp_req, exp_valid, exp_busy;
    logic [31:0] exp_addr;

    ibex_imem_req_ctrl #(.NUM_REQS(NUM_REQS)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .branch_i       (branch),
        .addr_i         (addr),
        .fifo_ready_i   (ready),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (gnt),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (rvalid),
        .instr_rdata_i  (rdata),
        .instr_err_i    (err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_fetch   = 32'h0;
        m_pending = 1'b0;
        mq.delete();
    endtask

    task automatic model_comb();
        exp_req   = (req && ready && mq.size() < NUM_REQS) || m_pending;
        exp_addr  = branch ? (addr & ~32'h3) : m_fetch;
        exp_valid = rvalid && mq.size() > 0 && !mq[0];
        exp_busy  = exp_req || mq.size() > 0;
    endtask

    task automatic model_update();
        if (rvalid && mq.size() > 0) void'(mq.pop_front());
        if (branch) foreach (mq[i]) mq[i] = 1'b1;
        if (exp_req && gnt) begin
            mq.push_back(1'b0);
            m_fetch = exp_addr + 32'd4;
        end else if (branch) begin
            m_fetch = addr & ~32'h3;
        end
        m_pending = exp_req && !gnt;
    endtask

    task automatic idle();
        req = 0; branch = 0; addr = 0; ready = 1; gnt = 0; rvalid = 0; rdata = 0; err = 0;
    endtask

    // Inputs are driven just after the falling edge; outputs are sampled 1 unit later.
    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic tick();
        model_comb();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        branch = 1; addr = 32'h402;
        settle();
        checks += 4;
        if (instr_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", instr_req_o); end
        if (fifo_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", fifo_valid_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        if (fifo_clear_o !== 1'b1) begin failures++; $display("FAIL reset_clear got=%b exp=1", fifo_clear_o); end
        idle();
        tick();
        rst_n = 1;
        model_reset();
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 3; i++) begin
            idle();
            req = 1; gnt = 1;
            if (i == 0) begin branch = 1; addr = 32'h100; end
            else begin rvalid = 1; rdata = 32'hA000_0000 + i; end
            settle();
            checks += 3;
            if (instr_addr_o !== 32'h100 + 4 * i) begin failures++; $display("FAIL stream_addr%0d got=%h exp=%h", i, instr_addr_o, 32'h100 + 4 * i); end
            if (fifo_valid_o !== (i > 0)) begin failures++; $display("FAIL stream_valid%0d got=%b exp=%b", i, fifo_valid_o, i > 0); end
            if (i > 0 && fifo_rdata_o !== 32'hA000_0000 + i) begin failures++; $display("FAIL stream_rdata%0d got=%h", i, fifo_rdata_o); end
            tick();
        end
        idle();
        rvalid = 1;
        settle();
        checks += 2;
        if (fifo_valid_o !== 1'b1) begin failures++; $display("FAIL stream_last_valid got=%b exp=1", fifo_valid_o); end
        if (instr_req_o !== 1'b0) begin failures++; $display("FAIL stream_last_req got=%b exp=0", instr_req_o); end
        tick();
        idle();
        settle();
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL stream_idle_busy got=%b exp=0", busy_o); end
    endtask

    task automatic test_grant_stall();
        idle();
        req = 1; branch = 1; addr = 32'h200;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks += 2;
            if (instr_req_o !== 1'b1) begin failures++; $display("FAIL stall_req%0d got=%b exp=1", i, instr_req_o); end
            if (instr_addr_o !== 32'h200) begin failures++; $display("FAIL stall_addr%0d got=%h exp=00000200", i, instr_addr_o); end
            tick();
            branch = 0;
            if (i == 0) begin req = 0; ready = 0; end
        end
        gnt = 1;
        settle();
        checks += 2;
        if (instr_req_o !== 1'b1) begin failures++; $display("FAIL stall_gnt_req got=%b exp=1", instr_req_o); end
        if (instr_addr_o !== 32'h200) begin failures++; $display("FAIL stall_gnt_addr got=%h exp=00000200", instr_addr_o); end
        tick();
        idle();
        settle();
        checks++;
        if (instr_req_o !== 1'b0) begin failures++; $display("FAIL stall_after_req got=%b exp=0", instr_req_o); end
        rvalid = 1;
        settle();
        checks++;
        if (fifo_valid_o !== 1'b1) begin failures++; $display("FAIL stall_resp_valid got=%b exp=1", fifo_valid_o); end
        tick();
    endtask

    task automatic test_branch_outstanding();
        idle();
        req = 1; gnt = 1; branch = 1; addr = 32'h100;
        tick();
        branch = 0;
        tick();
        gnt = 0; branch = 1; addr = 32'h402;
        settle();
        checks += 4;
        if (fifo_clear_o !== 1'b1) begin failures++; $display("FAIL br2_clear got=%b exp=1", fifo_clear_o); end
        if (fifo_addr_o !== 32'h402) begin failures++; $display("FAIL br2_fifo_addr got=%h exp=00000402", fifo_addr_o); end
        if (instr_addr_o !== 32'h400) begin failures++; $display("FAIL br2_instr_addr got=%h exp=00000400", instr_addr_o); end
        if (instr_req_o !== 1'b0) begin failures++; $display("FAIL br2_full_req got=%b exp=0", instr_req_o); end
        tick();
        branch = 0; rvalid = 1;
        settle();
        checks++;
        if (fifo_valid_o !== 1'b0) begin failures++; $display("FAIL br2_drop0 got=%b exp=0", fifo_valid_o); end
        tick();
        gnt = 1;
        settle();
        checks += 3;
        if (fifo_valid_o !== 1'b0) begin failures++; $display("FAIL br2_drop1 got=%b exp=0", fifo_valid_o); end
        if (instr_req_o !== 1'b1) begin failures++; $display("FAIL br2_new_req got=%b exp=1", instr_req_o); end
        if (instr_addr_o !== 32'h400) begin failures++; $display("FAIL br2_new_addr got=%h exp=00000400", instr_addr_o); end
        tick();
        idle();
        rvalid = 1;
        settle();
        checks++;
        if (fifo_valid_o !== 1'b1) begin failures++; $display("FAIL br2_keep got=%b exp=1", fifo_valid_o); end
        tick();
    endtask

    task automatic test_branch_gnt_rvalid();
        idle();
        req = 1; gnt = 1; branch = 1; addr = 32'h300;
        tick();
        addr = 32'h500; rvalid = 1;
        settle();
        checks += 3;
        if (fifo_valid_o !== 1'b1) begin failures++; $display("FAIL bgr_retire got=%b exp=1", fifo_valid_o); end
        if (instr_req_o !== 1'b1) begin failures++; $display("FAIL bgr_req got=%b exp=1", instr_req_o); end
        if (instr_addr_o !== 32'h500) begin failures++; $display("FAIL bgr_addr got=%h exp=00000500", instr_addr_o); end
        tick();
        idle();
        rvalid = 1;
        settle();
        checks += 2;
        if (fifo_valid_o !== 1'b1) begin failures++; $display("FAIL bgr_new_kept got=%b exp=1", fifo_valid_o); end
        if (busy_o !== 1'b1) begin failures++; $display("FAIL bgr_busy got=%b exp=1", busy_o); end
        tick();
        idle();
        settle();
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL bgr_drained got=%b exp=0", busy_o); end
    endtask

    task automatic test_backpressure();
        idle();
        req = 1; ready = 0;
        settle();
        checks++;
        if (instr_req_o !== 1'b0) begin failures++; $display("FAIL bp_noready got=%b exp=0", instr_req_o); end
        tick();
        ready = 1;
        tick();
        ready = 0;
        settle();
        checks++;
        if (instr_req_o !== 1'b1) begin failures++; $display("FAIL bp_hold got=%b exp=1", instr_req_o); end
        gnt = 1;
        tick();
        ready = 1;
        tick();
        settle();
        checks++;
        if (instr_req_o !== 1'b0) begin failures++; $display("FAIL bp_full got=%b exp=0", instr_req_o); end
        gnt = 0; rvalid = 1;
        settle();
        checks += 2;
        if (instr_req_o !== 1'b0) begin failures++; $display("FAIL bp_full_rv got=%b exp=0", instr_req_o); end
        if (fifo_valid_o !== 1'b1) begin failures++; $display("FAIL bp_resp0 got=%b exp=1", fifo_valid_o); end
        tick();
        req = 0;
        tick();
        idle();
    endtask

    task automatic test_err_wrap();
        idle();
        req = 1; gnt = 1; branch = 1; addr = 32'hFFFF_FFFC;
        settle();
        checks++;
        if (instr_addr_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", instr_addr_o); end
        tick();
        branch = 0; rvalid = 1; err = 1;
        settle();
        checks += 3;
        if (instr_addr_o !== 32'h0) begin failures++; $display("FAIL wrap_addr1 got=%h exp=00000000", instr_addr_o); end
        if (fifo_valid_o !== 1'b1) begin failures++; $display("FAIL err_valid got=%b exp=1", fifo_valid_o); end
        if (fifo_err_o !== 1'b1) begin failures++; $display("FAIL err_flag got=%b exp=1", fifo_err_o); end
        tick();
        gnt = 0; err = 0;
        tick();
        idle();
        settle();
        checks += 2;
        if (instr_req_o !== 1'b1) begin failures++; $display("FAIL rst_stall_req got=%b exp=1", instr_req_o); end
        if (instr_addr_o !== 32'h4) begin failures++; $display("FAIL rst_stall_addr got=%h exp=00000004", instr_addr_o); end
        #2;
        rst_n = 0;
        #1;
        checks += 2;
        if (instr_req_o !== 1'b0) begin failures++; $display("FAIL rst_mid_req got=%b exp=0", instr_req_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy_o); end
        @(negedge clk);
        tick();
        rst_n = 1;
        model_reset();
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            idle();
            req    = ($urandom_range(0, 3) != 0);
            ready  = ($urandom_range(0, 4) != 0);
            branch = ($urandom_range(0, 7) == 0);
            addr   = $urandom;
            gnt    = $urandom_range(0, 1);
            rvalid = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
            rdata  = $urandom;
            err    = $urandom_range(0, 1);
            settle();
            checks += 7;
            if (instr_req_o !== exp_req) begin failures++; $display("FAIL rnd_req n=%0d got=%b exp=%b", n, instr_req_o, exp_req); end
            if (instr_addr_o !== exp_addr) begin failures++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, instr_addr_o, exp_addr); end
            if (fifo_valid_o !== exp_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, fifo_valid_o, exp_valid); end
            if (busy_o !== exp_busy) begin failures++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy_o, exp_busy); end
            if (fifo_clear_o !== branch) begin failures++; $display("FAIL rnd_clear n=%0d got=%b exp=%b", n, fifo_clear_o, branch); end
            if (fifo_addr_o !== (addr & ~32'h1)) begin failures++; $display("FAIL rnd_fifo_addr n=%0d got=%h exp=%h", n, fifo_addr_o, addr & ~32'h1); end
            if (fifo_rdata_o !== rdata || fifo_err_o !== err) begin failures++; $display("FAIL rnd_data n=%0d got=%h/%b exp=%h/%b", n, fifo_rdata_o, fifo_err_o, rdata, err); end
            tick();
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_streaming();
        test_grant_stall();
        test_branch_outstanding();
        test_branch_gnt_rvalid();
        test_backpressure();
        test_err_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
